// File: rtl/wb_read_cache.sv
// rtl/wb_read_cache.sv - direct-mapped write-through single-word-line Wishbone read cache
module wb_read_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:31] s_adr_i,
  input  logic [0:31] s_dat_i,
  output logic [0:31] s_dat_o,
  input  logic        s_we_i,
  input  logic [0:3]  s_sel_i,
  input  logic        s_stb_i,
  input  logic        s_cyc_i,
  output logic        s_ack_o,
  output logic [2:31] m_adr_o,
  output logic [0:31] m_dat_o,
  input  logic [0:31] m_dat_i,
  output logic        m_we_o,
  output logic [0:3]  m_sel_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  input  logic        m_ack_i,
  input  logic        flush_i
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [2:0] {CLEAR, IDLE, LOOKUP, FILL, WRITE, ACK} state_t;

  state_t state, state_nxt;
  logic [INDEX_BITS-1:0] clr_cnt;
  logic                  flush_pend;

  logic [2:31] adr_q;
  logic [0:31] dat_q;
  logic [0:3]  sel_q;
  logic        we_q;
  logic        hit_q;

  logic              valid    [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [0:31]       data_mem [DEPTH];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag_in;
  logic                  hit;
  logic [0:31]           merged;

  logic        s_ack_nxt, m_cyc_nxt, m_we_nxt;
  logic [0:31] s_dat_nxt, m_dat_nxt;
  logic [2:31] m_adr_nxt;
  logic [0:3]  m_sel_nxt;

  assign idx    = adr_q[32-INDEX_BITS:31];
  assign tag_in = adr_q[2:31-INDEX_BITS];
  assign hit    = valid[idx] && (tag_mem[idx] == tag_in);

  // Write-hit merge: sel bit b covers byte b, where byte 0 is dat[0:7].
  always_comb begin
    merged = data_mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (sel_q[b]) merged[8*b +: 8] = dat_q[8*b +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (!flush_i && clr_cnt == {INDEX_BITS{1'b1}}) state_nxt = IDLE;
      IDLE: begin
        if (flush_pend || flush_i)   state_nxt = CLEAR;
        else if (s_cyc_i && s_stb_i) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (we_q)     state_nxt = WRITE;
        else if (hit) state_nxt = ACK;
        else          state_nxt = FILL;
      end
      FILL:    if (m_ack_i) state_nxt = ACK;
      WRITE:   if (m_ack_i) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    s_ack_nxt = 1'b0;
    s_dat_nxt = s_dat_o;
    m_cyc_nxt = m_cyc_o;
    m_we_nxt  = m_we_o;
    m_adr_nxt = m_adr_o;
    m_dat_nxt = m_dat_o;
    m_sel_nxt = m_sel_o;
    case (state)
      LOOKUP: begin
        if (we_q) begin
          m_cyc_nxt = 1'b1;
          m_we_nxt  = 1'b1;
          m_adr_nxt = adr_q;
          m_dat_nxt = dat_q;
          m_sel_nxt = sel_q;
        end else if (hit) begin
          s_ack_nxt = 1'b1;
          s_dat_nxt = data_mem[idx];
        end else begin
          m_cyc_nxt = 1'b1;
          m_we_nxt  = 1'b0;
          m_adr_nxt = adr_q;
          m_sel_nxt = 4'b1111;
        end
      end
      // An upstream abort still finishes downstream but gets no ack.
      FILL: if (m_ack_i) begin
        m_cyc_nxt = 1'b0;
        s_ack_nxt = s_cyc_i;
        s_dat_nxt = m_dat_i;
      end
      WRITE: if (m_ack_i) begin
        m_cyc_nxt = 1'b0;
        s_ack_nxt = s_cyc_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      flush_pend <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      hit_q      <= 1'b0;
      s_ack_o    <= 1'b0;
      s_dat_o    <= '0;
      m_cyc_o    <= 1'b0;
      m_stb_o    <= 1'b0;
      m_we_o     <= 1'b0;
      m_adr_o    <= '0;
      m_dat_o    <= '0;
      m_sel_o    <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_cnt <= flush_i ? '0 : clr_cnt + 1'b1;
      else                clr_cnt <= '0;
      if (state_nxt == CLEAR) flush_pend <= 1'b0;
      else if (flush_i)       flush_pend <= 1'b1;
      if (state == IDLE && state_nxt == LOOKUP) begin
        adr_q <= s_adr_i;
        dat_q <= s_dat_i;
        sel_q <= s_sel_i;
        we_q  <= s_we_i;
      end
      if (state == LOOKUP) hit_q <= hit;
      s_ack_o <= s_ack_nxt;
      s_dat_o <= s_dat_nxt;
      m_cyc_o <= m_cyc_nxt;
      m_stb_o <= m_cyc_nxt;
      m_we_o  <= m_we_nxt;
      m_adr_o <= m_adr_nxt;
      m_dat_o <= m_dat_nxt;
      m_sel_o <= m_sel_nxt;
    end
  end

  // Line storage has no reset; CLEAR invalidates it one index per cycle.
  always_ff @(posedge clk) begin
    if (state == CLEAR) valid[clr_cnt] <= 1'b0;
    if (state == FILL && m_ack_i) begin
      valid[idx]    <= 1'b1;
      tag_mem[idx]  <= tag_in;
      data_mem[idx] <= m_dat_i;
    end
    if (state == WRITE && m_ack_i && hit_q) data_mem[idx] <= merged;
  end

endmodule

// File: tb/tb_wb_read_cache.sv
// tb/tb_wb_read_cache.sv - directed vector bench for wb_read_cache
module tb_wb_read_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:31] s_adr_i;
  logic [0:31] s_dat_i;
  logic [0:31] s_dat_o;
  logic        s_we_i;
  logic [0:3]  s_sel_i;
  logic        s_stb_i;
  logic        s_cyc_i;
  logic        s_ack_o;
  logic [2:31] m_adr_o;
  logic [0:31] m_dat_o;
  logic [0:31] m_dat_i;
  logic        m_we_o;
  logic [0:3]  m_sel_o;
  logic        m_stb_o;
  logic        m_cyc_o;
  logic        m_ack_i;
  logic        flush_i;

  wb_read_cache #(.INDEX_BITS(6)) dut (
    .clk(clk), .reset(reset),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_we_i(s_we_i),
    .s_sel_i(s_sel_i), .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_ack_o(s_ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_ack_i(m_ack_i),
    .flush_i(flush_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Downstream slave: acks after ds_delay stalled cycles, logs each transfer.
  int          ds_delay = 0;
  int          wait_cnt = 0;
  int          ds_count = 0;
  logic [0:31] ds_rdata = '0;
  logic [2:31] last_adr;
  logic        last_we;
  logic [0:3]  last_sel;
  logic [0:31] last_dat;

  initial begin
    m_ack_i = 1'b0;
    m_dat_i = '0;
    forever begin
      @(negedge clk);
      if (m_cyc_o && m_stb_o && !m_ack_i) begin
        if (wait_cnt >= ds_delay) begin
          m_ack_i  = 1'b1;
          m_dat_i  = ds_rdata;
          ds_count = ds_count + 1;
          last_adr = m_adr_o;
          last_we  = m_we_o;
          last_sel = m_sel_o;
          last_dat = m_dat_o;
          wait_cnt = 0;
        end else begin
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        m_ack_i = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wb_access(input logic [2:31] adr, input logic we, input logic [0:31] wdat,
                           input logic [0:3] sel, output logic [0:31] rdat,
                           output int lat, output bit ok);
    @(negedge clk);
    s_adr_i = adr; s_we_i = we; s_dat_i = wdat; s_sel_i = sel;
    s_cyc_i = 1'b1; s_stb_i = 1'b1;
    lat = 0; ok = 1'b0;
    while (!ok && lat < 300) begin
      @(negedge clk);
      lat++;
      if (s_ack_o) ok = 1'b1;
    end
    rdat = s_dat_o;
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
  endtask

  typedef struct {
    logic [2:31] adr;
    logic        we;
    logic [0:31] wdat;
    logic [0:3]  sel;
    logic [0:31] ds_dat;
    logic [0:31] exp_dat;
    int          exp_lat;
    int          exp_ds;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [0:31] rdat;
    logic [2:31] r_adr;
    logic [0:31] r_dat;
    logic [0:3]  r_sel;
    logic        r_we;
    int lat, ds0, first_mcyc, first_ack, stall;
    bit ok;

    vecs[0]  = '{30'h100, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 3, 1};
    vecs[1]  = '{30'h100, 1'b0, 32'h0,        4'hF, 32'h00000000, 32'hDEADBEEF, 2, 0};
    vecs[2]  = '{30'h000, 1'b0, 32'h0,        4'hF, 32'hA0A0A0A0, 32'hA0A0A0A0, 3, 1};
    vecs[3]  = '{30'h040, 1'b0, 32'h0,        4'hF, 32'h40404040, 32'h40404040, 3, 1};
    vecs[4]  = '{30'h000, 1'b0, 32'h0,        4'hF, 32'hA0A0A0A1, 32'hA0A0A0A1, 3, 1};
    vecs[5]  = '{30'h100, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 3, 1};
    vecs[6]  = '{30'h100, 1'b1, 32'h11223344, 4'b0101, 32'h0,     32'h0,        3, 1};
    vecs[7]  = '{30'h100, 1'b0, 32'h0,        4'hF, 32'h00000000, 32'hDE22BE44, 2, 0};
    vecs[8]  = '{30'h2AB, 1'b1, 32'h55667788, 4'hF, 32'h0,        32'h0,        3, 1};
    vecs[9]  = '{30'h2AB, 1'b0, 32'h0,        4'hF, 32'h12345678, 32'h12345678, 3, 1};
    vecs[10] = '{30'h2AB, 1'b0, 32'h0,        4'hF, 32'h00000000, 32'h12345678, 2, 0};

    reset = 1'b1; flush_i = 1'b0;
    s_adr_i = '0; s_dat_i = '0; s_we_i = 1'b0; s_sel_i = '0; s_stb_i = 1'b0; s_cyc_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {s_ack_o, s_dat_o, m_cyc_o, m_stb_o, m_we_o},  '0);
    check("reset_m_bus", {m_adr_o, m_dat_o, m_sel_o}, '0);

    // Strobe a read in the very first cycle after reset; CLEAR must stall it.
    ds_rdata = 32'hCAFEF00D;
    reset = 1'b0;
    s_adr_i = 30'h3C5; s_we_i = 1'b0; s_sel_i = 4'hF; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    first_mcyc = 0; first_ack = 0;
    for (int c = 1; c <= 200 && first_ack == 0; c++) begin
      @(negedge clk);
      if (m_cyc_o && first_mcyc == 0) first_mcyc = c;
      if (s_ack_o) first_ack = c;
    end
    rdat = s_dat_o;
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    check("clear_first_mcyc", first_mcyc, 66);
    check("clear_first_ack", first_ack, 67);
    check("clear_read_data", rdat, 32'hCAFEF00D);

    foreach (vecs[i]) begin
      ds_rdata = vecs[i].ds_dat;
      ds0 = ds_count;
      wb_access(vecs[i].adr, vecs[i].we, vecs[i].wdat, vecs[i].sel, rdat, lat, ok);
      check($sformatf("v%0d_ack", i), ok, 1'b1);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_ds_count", i), ds_count - ds0, vecs[i].exp_ds);
      if (!vecs[i].we) check($sformatf("v%0d_rdata", i), rdat, vecs[i].exp_dat);
      if (vecs[i].exp_ds == 1) begin
        check($sformatf("v%0d_m_adr", i), last_adr, vecs[i].adr);
        check($sformatf("v%0d_m_we", i), last_we, vecs[i].we);
        check($sformatf("v%0d_m_sel", i), last_sel, vecs[i].we ? vecs[i].sel : 4'hF);
        if (vecs[i].we) check($sformatf("v%0d_m_dat", i), last_dat, vecs[i].wdat);
      end
    end

    // Downstream stall: 20 cycles without m_ack_i on a write.
    ds_delay = 20;
    @(negedge clk);
    s_adr_i = 30'h155; s_we_i = 1'b1; s_dat_i = 32'h0BADF00D; s_sel_i = 4'b1100;
    s_cyc_i = 1'b1; s_stb_i = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (m_stb_o) ok = 1'b1;
    end
    check("stall_m_stb_seen", ok, 1'b1);
    r_adr = m_adr_o; r_dat = m_dat_o; r_sel = m_sel_o; r_we = m_we_o;
    check("stall_first_bus", {r_adr, r_dat, r_sel, r_we}, {30'h155, 32'h0BADF00D, 4'b1100, 1'b1});
    stall = 0;
    while (m_stb_o && stall < 100) begin
      stall++;
      check("stall_bus_stable", {m_adr_o, m_dat_o, m_sel_o, m_we_o}, {r_adr, r_dat, r_sel, r_we});
      check("stall_no_ack", s_ack_o, 1'b0);
      @(negedge clk);
    end
    check("stall_cycles", stall, 21);
    check("stall_ack_after", s_ack_o, 1'b1);
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    ds_delay = 0;

    // Flush while the fill is outstanding: fill still completes, line then gone.
    ds_delay = 3;
    ds_rdata = 32'h0AA0AA00;
    @(negedge clk);
    s_adr_i = 30'h0AA; s_we_i = 1'b0; s_sel_i = 4'hF; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (m_stb_o) ok = 1'b1;
    end
    check("flush_fill_started", ok, 1'b1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (s_ack_o) ok = 1'b1;
      else @(negedge clk);
    end
    check("flush_fill_ack", ok, 1'b1);
    check("flush_fill_data", s_dat_o, 32'h0AA0AA00);
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    ds_delay = 0;
    ds_rdata = 32'h0AA0AA01;
    ds0 = ds_count;
    wb_access(30'h0AA, 1'b0, 32'h0, 4'hF, rdat, lat, ok);
    check("after_flush_ds_count", ds_count - ds0, 1);
    check("after_flush_rdata", rdat, 32'h0AA0AA01);
    check("after_flush_latency", lat, 68);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_read_cache.md
# wb_read_cache

Direct-mapped, write-through, single-word-line read cache between the CPU Wishbone master and the DDR2 MIG bridge. Read hits return in two cycles without touching DDR2. Misses and all writes are forwarded unchanged to the bridge's Wishbone slave port. The block runs entirely in the CPU clock domain and never sees the MIG's `ui_clk`.

## Interface
- `INDEX_BITS`, default 6: line index width. The cache holds 2^INDEX_BITS lines of 32 bits each. Legal range is 2..10.
- `clk` input 1: CPU clock, the same clock as the bridge's `cpu_clk`.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `s_adr_i` input [2:31]: upstream word address, big-endian bit numbering.
- `s_dat_i` input [0:31]: upstream write data.
- `s_dat_o` output [0:31]: upstream read data, registered.
- `s_we_i` input 1: upstream write enable.
- `s_sel_i` input [0:3]: byte selects. Bit 0 selects `dat[0:7]`.
- `s_stb_i`, `s_cyc_i` input 1: Wishbone classic strobe and cycle.
- `s_ack_o` output 1: registered single-cycle acknowledge.
- `m_adr_o` output [2:31]: downstream address.
- `m_dat_o` output [0:31]: downstream write data.
- `m_dat_i` input [0:31]: downstream read data.
- `m_we_o` output 1: downstream write enable.
- `m_sel_o` output [0:3]: downstream byte selects.
- `m_stb_o`, `m_cyc_o` output 1: downstream strobe and cycle.
- `m_ack_i` input 1: downstream acknowledge.
- `flush_i` input 1: pulse that invalidates all lines.

## Operation
- **Address split:**
  - index = `s_adr_i[32-INDEX_BITS:31]`.
  - tag = `s_adr_i[2:31-INDEX_BITS]`, which is 30-INDEX_BITS bits.
  - Storage per line: valid bit, tag, 32-bit data.
- **FSM states:** CLEAR, IDLE, LOOKUP, FILL, WRITE, ACK.
- **CLEAR**
  - Entered from reset or on flush. Walks a counter from 0 to 2^INDEX_BITS-1, clearing one valid bit per cycle.
  - Moves to IDLE after the last index.
  - Upstream requests are stalled during CLEAR: no ack is issued.
- **IDLE**
  - When `s_cyc_i & s_stb_i` are high, latch address, data, sel and we, then go to LOOKUP.
  - If a flush is pending, go to CLEAR first; a flush has priority over a new request.
- **LOOKUP**, hit = valid & tag match:
  - Read hit: `s_dat_o` ← line data, `s_ack_o` ← 1, then ACK.
  - Read miss: assert `m_cyc_o`/`m_stb_o`, `m_we_o`=0, `m_sel_o`=4'b1111, `m_adr_o`=latched address, then FILL.
  - Write, hit or miss: assert `m_cyc_o`/`m_stb_o`, `m_we_o`=1, `m_sel_o`=latched sel, `m_dat_o`=latched data, then WRITE. The hit flag is held for WRITE.
- **FILL**
  - Hold the downstream outputs stable until `m_ack_i`.
  - On `m_ack_i`: drop `m_cyc_o`/`m_stb_o`, write the line (valid=1, tag, `m_dat_i`), `s_dat_o` ← `m_dat_i`, `s_ack_o` ← 1, then ACK.
- **WRITE**
  - Hold the downstream outputs until `m_ack_i`.
  - On `m_ack_i`: drop the strobes and `s_ack_o` ← 1.
  - If the access was a hit, merge the selected bytes into the line; the tag and valid bit are unchanged.
  - If the access was a miss, there is no allocation.
  - Then ACK.
- **ACK:** `s_ack_o` ← 0, then IDLE. ACK is one cycle, so an upstream strobe is never double-acknowledged.
- **Flush**
  - A `flush_i` pulse in any state sets a pending flag. The flag is cleared on entry to CLEAR.
  - A flush during CLEAR restarts the counter at 0.
  - A transaction already in flight completes normally. A read fill that completes after the flush request still writes its line, and CLEAR then invalidates it.
- **Reset values:**
  - Outputs: `s_ack_o`=0, `s_dat_o`=0, `m_cyc_o`=`m_stb_o`=`m_we_o`=0, `m_adr_o`=0, `m_dat_o`=0, `m_sel_o`=0.
  - Internal: state=CLEAR, counter=0, flush pending=0.
- **Reset mid-transaction:** all outputs go to their reset values on the next edge. `reset` must be asserted together with the bridge's reset, because an abandoned downstream transaction is not recovered.
- **Upstream abort:** if `s_cyc_i` drops while in FILL or WRITE, the downstream transaction still completes and the line is still updated. `s_ack_o` is suppressed when `s_cyc_i` is low at the `m_ack_i` edge.

## Timing
- **CLEAR duration:** 2^INDEX_BITS cycles after reset deasserts. This is 64 cycles at the default.
- **Read hit:** strobe sampled at edge N, LOOKUP during N+1, `s_ack_o` and `s_dat_o` valid in cycle N+2.
- **Read miss and write:**
  - The downstream strobe goes high in cycle N+2.
  - `s_ack_o` is high in the cycle after the `m_ack_i` edge.
  - Added latency over a direct connection: 2 cycles.
- **Back-to-back:** the minimum spacing between upstream acks is 3 cycles.
- **Downstream signals:** `m_ack_i` is sampled only in FILL and WRITE. A stray `m_ack_i` in any other state is ignored.
- **Storage:** tag/data storage is read asynchronously in LOOKUP and written on a clock edge, so it maps to distributed RAM.

## Test plan
- **Reset/clear:** release `reset` and strobe a read at cycle 1. Required: no ack before cycle 64 + lookup, and `m_cyc_o` stays low until CLEAR ends.
- **Read miss then hit:** read addr 30'h100 with downstream returning 32'hDEADBEEF. Required: one downstream read with `m_sel_o`=4'hF, upstream data DEADBEEF. A repeat read of 30'h100 acks 2 cycles after the strobe with no downstream activity.
- **Conflict:** read 30'h040 (same index as 30'h000 at INDEX_BITS=6) after 30'h000 is cached. Required: miss. A subsequent read of 30'h000 misses again.
- **Write-through merge:** with 30'h100 cached as DEADBEEF, write 32'h11223344 with sel=4'b0101. Required: downstream write with the same sel and data, then a cached read returns 32'hDE22BE44. A write to an uncached address must not allocate: the next read of it misses.
- **Flush during fill:** assert `flush_i` while in FILL. Required: the fill completes and acks. CLEAR follows, and the next read of the same address misses.
- **Downstream stall:** hold `m_ack_i` low for 20 cycles. Required: `m_adr_o`, `m_dat_o`, `m_sel_o` and `m_we_o` stay stable, and `s_ack_o` stays low until 1 cycle after `m_ack_i`.
